// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-sequenced adder controller.
// Holds the FSM state encoding, the nibble width and the requester-id type.
package adder_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/adder_seq_ctrl_nibble.sv
// 4-bit ripple-carry adder (module nibble_adder), one full-adder cell per bit.
module nibble_adder
    import adder_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Two-requester controller that sequences one nibble adder over DATA_W/4 passes.
// Optional subtract support is built when ADDER_SUB_EN is defined.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,
    output logic              req1_ready,
    output logic              res_valid,
    output logic [DATA_W:0]   res_sum,
    output req_id_t           res_id,
    input  logic              res_ready,
    output state_t            dbg_state
);

    localparam int N     = DATA_W / NIB_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [DATA_W:0]    res_sum_q, res_sum_d;
    req_id_t            res_id_q, res_id_d;
    req_id_t            last_q, last_d;
    logic               op_q, op_d;

    req_id_t            grant_id;
    logic               can_accept;
    logic               grant_sub;
    logic [NIB_W-1:0]   a_nib, b_nib, nib_sum;
    logic               nib_cout;

`ifdef ADDER_SUB_EN
    assign grant_sub = grant_id ? req1_sub : req0_sub;
    assign b_nib     = op_q ? ~b_q[NIB_W*int'(idx_q) +: NIB_W] : b_q[NIB_W*int'(idx_q) +: NIB_W];
`else
    logic unused_sub;
    assign unused_sub = req0_sub ^ req1_sub ^ op_q;
    assign grant_sub  = 1'b0;
    assign b_nib      = b_q[NIB_W*int'(idx_q) +: NIB_W];
`endif

    assign a_nib = a_q[NIB_W*int'(idx_q) +: NIB_W];

    nibble_adder u_nib (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // With both requesting, the one that was not served last wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = !req0_valid;
        end
        can_accept = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = can_accept && (grant_id == 1'b0);
        req1_ready = can_accept && (grant_id == 1'b1);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_sum_d = res_sum_q;
        res_id_d  = res_id_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (can_accept) begin
                    a_d      = grant_id ? req1_a : req0_a;
                    b_d      = grant_id ? req1_b : req0_b;
                    op_d     = grant_sub;
                    carry_d  = grant_sub;
                    res_id_d = grant_id;
                    last_d   = grant_id;
                    idx_d    = '0;
                    state_d  = ADD;
                end
            end
            ADD: begin
                res_sum_d[NIB_W*int'(idx_q) +: NIB_W] = nib_sum;
                carry_d = nib_cout;
                if (idx_q == IDX_W'(N - 1)) begin
                    res_sum_d[DATA_W] = nib_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            res_sum_q <= '0;
            res_id_q  <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_sum_q <= res_sum_d;
            res_id_q  <= res_id_d;
            last_q    <= last_d;
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign dbg_state = state_q;

endmodule
